fact_unit: RTL

- Multi-cycle factorial engine in the ALU path, directly downstream of the control unit.
- Consumes the control unit's FACT request together with the selected X/Y register value, and computes n! using repeated shift-add multiplication.
- Returns the result, an overflow flag, and a one-cycle done pulse. The done pulse drives the control unit's FACT_END, which releases it from the EX state.

---
 rtl/fact_unit.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/fact_unit.sv
// Multi-cycle factorial engine: n! by repeated W-cycle shift-add multiplies,
// saturating to all-ones with ovf when the product no longer fits in W bits.
module fact_unit #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] operand,
  output logic [W-1:0] result,
  output logic         done,
  output logic         busy,
  output logic         ovf
);

  localparam int unsigned CW = $clog2(W);
  localparam int unsigned PW = 2 * W;

  typedef enum logic [2:0] {
    IDLE,
    MUL,
    CHECK,
    DONE,
    WAIT_LOW
  } state_t;

  state_t        state, state_d;
  logic [W-1:0]  acc, acc_d;
  logic [W-1:0]  cnt, cnt_d;
  logic [W-1:0]  mult, mult_d;
  logic [PW-1:0] prod, prod_d;
  logic [PW-1:0] mcand, mcand_d;
  logic [CW-1:0] k, k_d;
  logic [W-1:0]  result_d;
  logic          done_d, busy_d, ovf_d;

  // State and datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      acc    <= '0;
      cnt    <= '0;
      mult   <= '0;
      prod   <= '0;
      mcand  <= '0;
      k      <= '0;
      result <= W'(1);
      done   <= 1'b0;
      busy   <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      state  <= state_d;
      acc    <= acc_d;
      cnt    <= cnt_d;
      mult   <= mult_d;
      prod   <= prod_d;
      mcand  <= mcand_d;
      k      <= k_d;
      result <= result_d;
      done   <= done_d;
      busy   <= busy_d;
      ovf    <= ovf_d;
    end
  end

  // Next-state and datapath updates
  always_comb begin
    state_d  = state;
    acc_d    = acc;
    cnt_d    = cnt;
    mult_d   = mult;
    prod_d   = prod;
    mcand_d  = mcand;
    k_d      = k;
    result_d = result;
    ovf_d    = ovf;

    case (state)
      IDLE: begin
        if (start) begin
          ovf_d = 1'b0;
          if (operand <= W'(1)) begin
            result_d = W'(1);
            state_d  = DONE;
          end else begin
            acc_d   = W'(1);
            cnt_d   = operand;
            prod_d  = '0;
            mcand_d = {{W{1'b0}}, acc_d};
            mult_d  = operand;
            k_d     = '0;
            state_d = MUL;
          end
        end
      end

      MUL: begin
        if (mult[0]) begin
          prod_d = prod + mcand;
        end
        mcand_d = mcand << 1;
        mult_d  = mult >> 1;
        k_d     = k + CW'(1);
        if (k == CW'(W - 1)) begin
          state_d = CHECK;
        end
      end

      CHECK: begin
        if (prod[PW-1:W] != '0) begin
          result_d = '1;
          ovf_d    = 1'b1;
          state_d  = DONE;
        end else begin
          acc_d = prod[W-1:0];
          cnt_d = cnt - W'(1);
          if (cnt_d == W'(1)) begin
            result_d = acc_d;
            state_d  = DONE;
          end else begin
            // Reload the multiplier for the next factor down
            prod_d  = '0;
            mcand_d = {{W{1'b0}}, acc_d};
            mult_d  = cnt_d;
            k_d     = '0;
            state_d = MUL;
          end
        end
      end

      DONE: begin
        state_d = start ? WAIT_LOW : IDLE;
      end

      WAIT_LOW: begin
        if (!start) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    done_d = (state_d == DONE);
    busy_d = (state_d == MUL) || (state_d == CHECK) || (state_d == DONE);
  end

endmodule
